load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-access stage between the execute stage and write_back_unit. Takes a load/store
//  request (byte address from the ALU, rs2 store data, funct3 width) and runs one transaction
//  on a ready/ack data bus. Returns sign/zero-extended load data that feeds write_back_unit
//  mem_data. Reports misaligned/illegal accesses and bus timeouts instead of accessing memory.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles bus_req is held without bus_ack before a bus error (>=2)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous active-high reset
//  start        in   1   request strobe; sampled only in IDLE
//  is_store     in   1   1=store, 0=load
//  funct3       in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
//  addr         in   32  byte address
//  store_data   in   32  rs2 value; low byte/half used for SB/SH
//  busy         out  1   high in every state except IDLE
//  done         out  1   one-cycle completion pulse (success or fault)
//  mem_data     out  32  extended load result; valid with done, held until next done
//  misaligned   out  1   with done: misaligned address or illegal funct3, no bus access made
//  bus_err      out  1   with done: timeout expired
//  bus_req      out  1   transaction request, held high until ack or timeout
//  bus_we       out  1   write enable, valid while bus_req
//  bus_addr     out  32  word address {addr[31:2],2'b00}
//  bus_wdata    out  32  lane-replicated store data
//  bus_wstrb    out  4   byte strobes (0000 for loads)
//  bus_rdata    in   32  read data, valid with bus_ack
//  bus_ack      in   1   one-cycle transaction acknowledge
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, mem_data 0, timeout counter 0. Reset mid-transaction
//   drops bus_req immediately (async) and discards the request; no done is produced.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: on start, latch all inputs. Legal -> WAIT with bus_req=1 on the next cycle.
//         Fault -> RESP with misaligned=1; bus_req is never raised.
//   WAIT: bus_req/bus_we/bus_addr/bus_wdata/bus_wstrb stable. On bus_ack: capture bus_rdata
//         (loads), go RESP. Otherwise counter++. Counter reaching TIMEOUT_CYCLES-1 with no
//         ack -> RESP with bus_err=1, mem_data=0. Ack in the same cycle as expiry: ack wins.
//   RESP: done=1 for exactly one cycle, flags valid; then IDLE. Counter cleared.
//  Latency: start at cycle 0, bus_req from cycle 1. Ack in cycle k gives done in cycle k+1.
//   Minimum is 2 cycles (ack in cycle 1). Fault path: done in cycle 1.
//  start while busy is ignored (no queueing). start is accepted again in the cycle after done.
//  Alignment: H/HU/SH need addr[0]=0; W/SW need addr[1:0]=00. Illegal funct3 (011,110,111;
//   or stores with funct3>010) is reported as misaligned.
//  Stores: SB wstrb=0001<<addr[1:0], wdata={4{sd[7:0]}}; SH wstrb=0011<<addr[1:0],
//   wdata={2{sd[15:0]}}; SW wstrb=1111, wdata=sd. mem_data=0 after a store.
//  Loads: lane=rdata>>(8*addr[1:0]). LB/LH sign-extend lane[7:0]/lane[15:0];
//   LBU/LHU zero-extend; LW passes rdata through.
//  Unused bus outputs are 0 outside WAIT.
// TESTING
//  1 LW addr=0x100, ack cycle 1, rdata=0xA5A5A5A5 -> bus_addr=0x100, wstrb=0, done cycle 2,
//    mem_data=0xA5A5A5A5.
//  2 LB addr=0x103, rdata=0x80FF1234 -> mem_data=0xFFFFFF80; LBU same -> 0x00000080;
//    LHU addr=0x102 -> 0x000080FF.
//  3 SB addr=0x201, sd=0x123456AB -> bus_we=1, wstrb=0010, wdata=0xABABABAB, bus_addr=0x200;
//    SH addr=0x202 -> wstrb=1100, wdata=0x56AB56AB.
//  4 LW addr=0x102, and LH addr=0x001 -> no bus_req, done cycle 1, misaligned=1.
//  5 No ack for TIMEOUT_CYCLES=16 -> bus_req high cycles 1..16, done+bus_err cycle 17,
//    mem_data=0. Repeat with ack in cycle 16 -> normal done, bus_err=0.
//  6 rst pulse while in WAIT -> bus_req=0 at once, no done. Second start while busy
//    -> ignored; start in the cycle after done -> accepted.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one load/store on a ready/ack bus, extends load data,
// and reports misaligned/illegal requests and bus timeouts with a one-cycle done pulse.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_next;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [31:0]     r_addr, r_sd;
  logic [CW-1:0]   r_cnt;
  logic            r_mis, r_berr;
  logic [31:0]     r_mem_data;
  logic            w_legal, w_accept, w_expire;

  function automatic logic access_legal(input logic st, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = (a[0] == 1'b0);
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = !st;
      3'b101:  ok = !st && (a[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << a;
      2'b01:   s = 4'b0011 << a;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{sd[7:0]}};
      2'b01:   d = {2{sd[15:0]}};
      default: d = sd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rd);
    logic [31:0] lane, r;
    lane = rd >> {a, 3'b000};
    case (f3)
      3'b000:  r = {{24{lane[7]}}, lane[7:0]};
      3'b001:  r = {{16{lane[15]}}, lane[15:0]};
      3'b100:  r = {24'd0, lane[7:0]};
      3'b101:  r = {16'd0, lane[15:0]};
      default: r = rd;
    endcase
    return r;
  endfunction

  assign w_legal  = access_legal(is_store, funct3, addr[1:0]);
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_expire = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_legal ? S_WAIT : S_RESP;
      S_WAIT:  if (bus_ack || w_expire) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_RESP);
    misaligned = done && r_mis;
    bus_err    = done && r_berr;
    bus_req    = (r_state == S_WAIT);
    bus_we     = 1'b0;
    bus_addr   = 32'd0;
    bus_wdata  = 32'd0;
    bus_wstrb  = 4'd0;
    if (bus_req) begin
      bus_we   = r_we;
      bus_addr = {r_addr[31:2], 2'b00};
      if (r_we) begin
        bus_wdata = store_lanes(r_funct3, r_sd);
        bus_wstrb = store_strb(r_funct3, r_addr[1:0]);
      end
    end
  end

  assign mem_data = r_mem_data;

  // Request fields are only observed while WAIT, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= is_store;
      r_funct3 <= funct3;
      r_addr   <= addr;
      r_sd     <= store_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_mis      <= 1'b0;
      r_berr     <= 1'b0;
      r_mem_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_cnt  <= '0;
          r_mis  <= !w_legal;
          r_berr <= 1'b0;
          if (!w_legal) r_mem_data <= 32'd0;
        end
        // Ack takes priority over an expiring timeout in the same cycle.
        S_WAIT: begin
          if (bus_ack) begin
            r_mem_data <= r_we ? 32'd0 : load_extend(r_funct3, r_addr[1:0], bus_rdata);
          end else if (w_expire) begin
            r_berr     <= 1'b1;
            r_mem_data <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP:  r_cnt <= '0;
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: load/store lanes, faults, timeout,
// async reset mid-transaction and start-while-busy behaviour.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, start, is_store, bus_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, bus_rdata;
  logic        busy, done, misaligned, bus_err, bus_req, bus_we;
  logic [31:0] mem_data, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  int total = 0;
  int bad   = 0;

  int          g_done_cyc, g_req_cnt, g_req_first;
  logic        g_we, g_mis, g_berr;
  logic [31:0] g_addr, g_wdata, g_mdata;
  logic [3:0]  g_wstrb;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .mem_data(mem_data), .misaligned(misaligned), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues a request in the current (idle) cycle, acks in cycle ack_at (0 = never),
  // records bus signals of cycle 1 and the outputs seen with done, then returns to idle.
  task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input int ack_at, input logic [31:0] rd);
    bit seen = 0;
    g_done_cyc = -1; g_req_cnt = 0; g_req_first = -1;
    g_we = 0; g_addr = 0; g_wdata = 0; g_wstrb = 0;
    start = 1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    tick;
    start = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin
        g_done_cyc = cyc; g_mis = misaligned; g_berr = bus_err; g_mdata = mem_data;
        seen = 1;
        break;
      end
      if (bus_req) begin
        g_req_cnt++;
        if (g_req_first < 0) g_req_first = cyc;
      end
      if (cyc == 1) begin
        g_we = bus_we; g_addr = bus_addr; g_wdata = bus_wdata; g_wstrb = bus_wstrb;
      end
      if (cyc == ack_at) begin bus_ack = 1; bus_rdata = rd; end
      tick;
      bus_ack = 0;
    end
    if (!seen) chk("done_bound", 0, 1);
    tick;
  endtask

  initial begin
    rst = 1; start = 0; is_store = 0; funct3 = 0; addr = 0; store_data = 0;
    bus_ack = 0; bus_rdata = 0;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_mdata", mem_data, 0);
    chk("rst_wstrb", bus_wstrb, 0);
    rst = 0;
    tick;

    run(0, 3'b010, 32'h100, 0, 1, 32'hA5A5A5A5);
    chk("lw_done_cyc", g_done_cyc, 2);
    chk("lw_addr", g_addr, 32'h100);
    chk("lw_we", g_we, 0);
    chk("lw_wstrb", g_wstrb, 0);
    chk("lw_mdata", g_mdata, 32'hA5A5A5A5);
    chk("lw_mis", g_mis, 0);
    chk("lw_held", mem_data, 32'hA5A5A5A5);

    run(0, 3'b000, 32'h103, 0, 2, 32'h80FF1234);
    chk("lb_done_cyc", g_done_cyc, 3);
    chk("lb_mdata", g_mdata, 32'hFFFFFF80);
    run(0, 3'b100, 32'h103, 0, 1, 32'h80FF1234);
    chk("lbu_mdata", g_mdata, 32'h00000080);
    run(0, 3'b101, 32'h102, 0, 1, 32'h80FF1234);
    chk("lhu_mdata", g_mdata, 32'h000080FF);
    run(0, 3'b001, 32'h102, 0, 1, 32'h80FF1234);
    chk("lh_mdata", g_mdata, 32'hFFFF80FF);

    run(1, 3'b000, 32'h201, 32'h123456AB, 1, 0);
    chk("sb_we", g_we, 1);
    chk("sb_wstrb", g_wstrb, 4'b0010);
    chk("sb_wdata", g_wdata, 32'hABABABAB);
    chk("sb_addr", g_addr, 32'h200);
    chk("sb_mdata", g_mdata, 0);
    run(1, 3'b001, 32'h202, 32'h123456AB, 1, 0);
    chk("sh_wstrb", g_wstrb, 4'b1100);
    chk("sh_wdata", g_wdata, 32'h56AB56AB);
    run(1, 3'b010, 32'h204, 32'h123456AB, 1, 0);
    chk("sw_wstrb", g_wstrb, 4'b1111);
    chk("sw_wdata", g_wdata, 32'h123456AB);

    run(0, 3'b010, 32'h102, 0, 1, 0);
    chk("mis_lw_cyc", g_done_cyc, 1);
    chk("mis_lw_flag", g_mis, 1);
    chk("mis_lw_req", g_req_cnt, 0);
    run(0, 3'b001, 32'h001, 0, 1, 0);
    chk("mis_lh_cyc", g_done_cyc, 1);
    chk("mis_lh_flag", g_mis, 1);
    run(0, 3'b011, 32'h000, 0, 1, 0);
    chk("ill_ld_flag", g_mis, 1);
    run(1, 3'b100, 32'h000, 0, 1, 0);
    chk("ill_st_flag", g_mis, 1);
    chk("ill_st_req", g_req_cnt, 0);

    run(0, 3'b010, 32'h300, 0, 1, 32'hDEADBEEF);
    run(0, 3'b010, 32'h300, 0, 0, 0);
    chk("to_first", g_req_first, 1);
    chk("to_req_cnt", g_req_cnt, 16);
    chk("to_done_cyc", g_done_cyc, 17);
    chk("to_berr", g_berr, 1);
    chk("to_mdata", g_mdata, 0);
    run(0, 3'b010, 32'h300, 0, 16, 32'h11223344);
    chk("ack16_cyc", g_done_cyc, 17);
    chk("ack16_berr", g_berr, 0);
    chk("ack16_mdata", g_mdata, 32'h11223344);

    // Reset in the middle of WAIT.
    start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h400;
    tick;
    start = 0;
    chk("mid_req", bus_req, 1);
    tick;
    #3 rst = 1;
    #1;
    chk("rst_async_req", bus_req, 0);
    chk("rst_async_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_nodone", done, 0);
    end
    rst = 0;
    tick;
    chk("post_rst_busy", busy, 0);

    // Start held while busy must not replace the request.
    start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h300;
    tick;
    addr = 32'h404;
    chk("busy_addr1", bus_addr, 32'h300);
    tick;
    chk("busy_addr2", bus_addr, 32'h300);
    start = 0;
    bus_ack = 1; bus_rdata = 32'h0BADF00D;
    tick;
    bus_ack = 0;
    chk("busy_done", done, 1);
    chk("busy_mdata", mem_data, 32'h0BADF00D);
    tick;
    run(0, 3'b010, 32'h500, 0, 1, 32'h55AA55AA);
    chk("next_done_cyc", g_done_cyc, 2);
    chk("next_addr", g_addr, 32'h500);
    chk("next_mdata", g_mdata, 32'h55AA55AA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
